task1: RTL and testbench
========================

// Module: task1
//
// PURPOSE
// - Small register-file/multiply datapath: captures two operands on a write strobe,
//   multiplies the stored operands into a result register on a multiply strobe,
//   and drives the stored result on the output when display is asserted.
// - Standalone memory/register exercise block; no handshake with neighbours.
//
// PARAMETERS
// - p_data_width  8  width of each operand; result and output are 2*p_data_width
//
// PORTS
// - i_w_clk       in   1       single clock; all state updates on rising edge
// - i_w_reset     in   1       reset, asynchronous, active-high
// - i_w_a         in   W       operand A (W = p_data_width)
// - i_w_b         in   W       operand B
// - i_w_write     in   1       load i_w_a/i_w_b into operand registers
// - i_w_multiply  in   1       load r_a*r_b into result register
// - i_w_display   in   1       drive result register onto o_w_out
// - o_w_out       out  2*W     displayed result, else 0
//
// BEHAVIOUR
// - State: r_a[W-1:0], r_b[W-1:0], r_prod[2W-1:0].
// - Reset (i_w_reset=1, async, dominates all strobes): r_a=r_b=r_prod=0; o_w_out=0.
// - write=1 at rising edge: r_a<=i_w_a, r_b<=i_w_b; else hold.
// - multiply=1 at rising edge: r_prod<=r_a*r_b; unsigned, full 2W-bit product,
//   no truncation or overflow possible; else hold.
// - write and multiply in the same cycle: multiply uses OLD r_a/r_b (pre-edge values);
//   new operands visible to a multiply one cycle later.
// - o_w_out is combinational from state: display ? r_prod : 0. No clock latency
//   on display; a product becomes visible the cycle after the multiply edge.
// - multiply and display together: output shows old r_prod until the edge, new after.
// - All strobes low: all registers hold; output follows display only.
// - Reset mid-operation: registers clear immediately (not edge-aligned); after
//   release, a multiply without a prior write yields 0.
// - Strobes are level-sensitive: held high, they reload every cycle (idempotent
//   for constant inputs).
//
// STRUCTURE
// - No shared package needed; optionally place default width constant (8) in the
//   team's common constants package.
// - One natural sub-module: en_register #(WIDTH) - async active-high reset to 0,
//   synchronous load enable; instantiated three times (r_a, r_b with WIDTH=W,
//   r_prod with WIDTH=2W). Multiplier and output mux stay in task1.
//
// TESTING
// - Reset: assert i_w_reset with random strobes -> o_w_out=0, all registers 0.
// - a=2,b=4: write 1 cycle, multiply 1 cycle, display=1 -> o_w_out=8; display=0 -> 0.
// - Multiply with no prior write after reset, display=1 -> o_w_out=0.
// - write+multiply same edge (old r_a=2,r_b=4; new a=3,b=5) -> out=8, next multiply -> 15.
// - Width corner: a=b=255 (W=8), write, multiply, display -> o_w_out=65025.
// - Reset asserted mid-edge-cycle after result 8 displayed -> o_w_out=0 immediately.

Source files
------------

// File: rtl/task1_pkg.sv
// Shared constants for the task1 operand/multiply datapath.
// No logic lives here.
package task1_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/task1_en_register.sv
// Load-enabled register, cleared to zero by asynchronous active-high reset.
// Latency: one clock from en to q; no backpressure (plain storage element).
module en_register
  import task1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/task1.sv
// Stores two operands, multiplies them into a result register, and shows the result when display is high.
// Latency: product visible one edge after multiply, display is combinational; no backpressure (strobe driven).
module task1
  import task1_pkg::*;
#(
  parameter int p_data_width = DEFAULT_DATA_WIDTH
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_reset,
  input  logic [p_data_width-1:0]   i_w_a,
  input  logic [p_data_width-1:0]   i_w_b,
  input  logic                      i_w_write,
  input  logic                      i_w_multiply,
  input  logic                      i_w_display,
  output logic [2*p_data_width-1:0] o_w_out
);

  localparam int W = p_data_width;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_prod;
  logic [2*W-1:0] prod_nxt;

  en_register #(.WIDTH(W)) u_reg_a (
    .clk (i_w_clk),
    .rst (i_w_reset),
    .en  (i_w_write),
    .d   (i_w_a),
    .q   (r_a)
  );

  en_register #(.WIDTH(W)) u_reg_b (
    .clk (i_w_clk),
    .rst (i_w_reset),
    .en  (i_w_write),
    .d   (i_w_b),
    .q   (r_b)
  );

  // Operands are widened first so the full 2W-bit product is kept; the
  // multiply reads the registered operands, so a same-edge write is not seen.
  assign prod_nxt = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};

  en_register #(.WIDTH(2*W)) u_reg_prod (
    .clk (i_w_clk),
    .rst (i_w_reset),
    .en  (i_w_multiply),
    .d   (prod_nxt),
    .q   (r_prod)
  );

  assign o_w_out = i_w_display ? r_prod : '0;

endmodule

// File: tb/tb_task1.sv
// Directed plus randomized bench for task1 against a reference model of the operand/product rules.
module tb_task1;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   a, b;
  logic           wr, mul, disp;
  logic [2*W-1:0] out;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: stored operands and product as plain integers.
  int unsigned ma, mb, mp;

  task1 #(.p_data_width(W)) dut (
    .i_w_clk      (clk),
    .i_w_reset    (rst),
    .i_w_a        (a),
    .i_w_b        (b),
    .i_w_write    (wr),
    .i_w_multiply (mul),
    .i_w_display  (disp),
    .o_w_out      (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*W-1:0] exp);
    vectors++;
    assert (out === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, out, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model_out(input logic d);
    logic [31:0] p;
    p = mp;
    return d ? p[2*W-1:0] : '0;
  endfunction

  // One clock of stimulus: check before the edge (old product) and after it.
  task automatic step(input logic w, input logic m, input logic d,
                      input logic [W-1:0] av, input logic [W-1:0] bv,
                      input string tag);
    int unsigned np;
    @(negedge clk);
    wr = w; mul = m; disp = d; a = av; b = bv;
    #1 check({tag, "/pre"}, model_out(d));
    @(posedge clk);
    np = m ? ma * mb : mp;
    if (w) begin
      ma = av;
      mb = bv;
    end
    mp = np;
    #1 check({tag, "/post"}, model_out(d));
  endtask

  // Reset raised away from any edge with random strobes; output must clear at once.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    wr  = 1'($urandom);
    mul = 1'($urandom);
    a   = W'($urandom);
    b   = W'($urandom);
    disp = 1'b1;
    rst = 1'b1;
    ma = 0; mb = 0; mp = 0;
    #1 check({tag, "/immediate"}, '0);
    @(posedge clk);
    #1 check({tag, "/held"}, '0);
    @(negedge clk);
    rst = 1'b0;
    wr = 1'b0; mul = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wr = 1'($urandom); mul = 1'($urandom); disp = 1'b1;
    a = W'($urandom); b = W'($urandom);
    ma = 0; mb = 0; mp = 0;
    #1 check("reset_at_start", '0);
    @(posedge clk);
    #1 check("reset_hold_edge", '0);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0; mul = 1'b0; disp = 1'b0;

    // Basic 2*4 with display on and off
    step(1, 0, 0, 8'd2, 8'd4, "wr_2_4");
    step(0, 1, 0, 8'd0, 8'd0, "mul_2_4");
    step(0, 0, 1, 8'd0, 8'd0, "disp_on");
    check("const_8", 16'd8);
    step(0, 0, 0, 8'd0, 8'd0, "disp_off");
    check("const_off", 16'd0);

    // Multiply without a prior write after reset
    async_reset("rst_a");
    step(0, 1, 1, 8'd9, 8'd9, "mul_nowrite");
    check("const_nowrite", 16'd0);

    // Write and multiply on the same edge use old operands
    step(1, 0, 0, 8'd2, 8'd4, "wr_2_4b");
    step(1, 1, 1, 8'd3, 8'd5, "wr_mul_same");
    check("const_old_8", 16'd8);
    step(0, 1, 1, 8'd0, 8'd0, "mul_3_5");
    check("const_15", 16'd15);

    // Width corner
    step(1, 0, 0, 8'd255, 8'd255, "wr_255");
    step(0, 1, 1, 8'd0, 8'd0, "mul_255");
    check("const_65025", 16'd65025);

    // Held strobes reload every cycle
    step(1, 1, 1, 8'd7, 8'd9, "hold_1");
    step(1, 1, 1, 8'd7, 8'd9, "hold_2");
    check("const_63", 16'd63);

    // Reset mid-cycle after 8 is displayed
    step(1, 0, 0, 8'd2, 8'd4, "wr_2_4c");
    step(0, 1, 1, 8'd0, 8'd0, "mul_2_4c");
    check("const_8c", 16'd8);
    async_reset("rst_mid");
    step(0, 1, 1, 8'd0, 8'd0, "mul_after_rst");
    check("const_after_rst", 16'd0);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step(1'($urandom), 1'($urandom), 1'($urandom),
             W'($urandom), W'($urandom), "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
